bpb_commit_queue: RTL
=====================

# bpb_commit_queue

Buffers resolved-branch updates from the two execute/commit slots and drains them, one per cycle, into the branch prediction buffer write port (`pc_commit`, `wen`, `destpc_commit`). It decouples the dual-issue resolution rate from the single-port BPB update path. It also absorbs cycles in which the BPB write is stalled. Overflowed updates are dropped and counted, which is safe because predictor updates are hints only.

## Interface
- `DEPTH`, 8: number of entries; a power of two and at least 4.
- `PTR_W`, `$clog2(DEPTH)`: pointer width; derived, do not override.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `stall`  in  1  BPB write stall; the same signal that gates the BPB update. No pop occurs while it is high.
- `in_valid`  in  2  per-slot resolved-branch strobe. Slot 0 is older than slot 1.
- `in_pc`  in  2x32  per-slot branch PC.
- `in_taken`  in  2  per-slot resolved direction.
- `in_destpc`  in  2x32  per-slot resolved target.
- `in_ready`  out  1  high when at least 2 entries are free. Advisory only.
- `wen`  out  1  head entry valid; this is the BPB write enable.
- `pc_commit`  out  32  head PC. Reads 0 when empty.
- `taken_commit`  out  1  head direction. Reads 0 when empty.
- `destpc_commit`  out  32  head target. Reads 0 when empty.
- `count`  out  PTR_W+1  number of occupied entries.
- `drop_cnt`  out  16  saturating count of dropped updates.

## Operation
- Storage is a circular FIFO of {pc, taken, destpc}, with head pointer `rd_ptr`, tail pointer `wr_ptr`, and `count`.
- The data array is not reset. All head outputs are forced to 0 when `count == 0`.
- Pop: when `wen && !stall`, at the clock edge `rd_ptr` advances by 1 modulo DEPTH.
- Push:
  - `free = DEPTH - count`, measured before any same-cycle pop. A same-cycle pop does not create room for same-cycle pushes.
  - `n_req = in_valid[0] + in_valid[1]`.
  - `n_acc = min(n_req, free)`.
  - Valid slots are written in order, slot 0 first, to `wr_ptr` and `wr_ptr+1` mod DEPTH. Invalid slots are skipped, so `in_valid == 2'b10` writes slot 1 at `wr_ptr`.
- Overflow:
  - `n_drop = n_req - n_acc`. The younger request is always the one dropped first.
  - `drop_cnt` increments by `n_drop`, saturating at 16'hFFFF. It holds the value 16'hFFFE+2 as 16'hFFFF.
- Count update: `count_next = count + n_acc - pop`. It never exceeds DEPTH and never underflows.
- Pointer arithmetic is modulo DEPTH through natural PTR_W wraparound.
- `in_ready = (free >= 2)`. It is combinational from `count` only, with no dependence on `in_valid`.
- No coalescing: identical PCs in both slots occupy two entries and are written to the BPB in order.
- Reset (asynchronous) clears `rd_ptr`, `wr_ptr`, `count`, and `drop_cnt`. The result is `wen=0`, `in_ready=1`, and all head outputs 0. Any in-flight entries are discarded.

## Timing
- Push-to-output latency is 1 cycle. An entry pushed at edge N appears at the head after edge N if the queue was empty. There is no combinational bypass from `in_*` to the head outputs.
- Head outputs and `wen` are combinational reads of registered state. They are stable for the whole cycle and change only at clock edges or on reset.
- Throughput is at most 1 pop per cycle and at most 2 pushes per cycle.
- Simultaneous push and pop:
  - Allowed in the same cycle.
  - When full, a pop plus 1 push still drops the push, because `free` is evaluated before the pop. The count goes from DEPTH to DEPTH-1.
- While `stall` is high, the head outputs hold and `wen` stays high if non-empty. The BPB ignores the write because it gates on `stall` itself.
- Reset asserted mid-cycle takes effect immediately. After deassertion, the first push is accepted at the first clock edge.

## Test plan
- **Reset, then idle:** `wen=0`, `count=0`, `in_ready=1`, `drop_cnt=0`, `pc_commit=0`.
- **Single push of slot 0** (pc=0xBFC00010, taken=1, destpc=0xBFC00100) with `stall=0`:
  - One cycle later: `wen=1` with those values.
  - Next cycle: `wen=0`, `count=0`.
- **Dual push, ordering:** slot0 pc=0x100, slot1 pc=0x200, `stall=1` for 3 cycles, then `stall=0`.
  - The head holds 0x100 while stalled.
  - After the stall releases: 0x100 then 0x200 on consecutive cycles.
  - `in_valid=2'b10` instead: only 0x200 is enqueued.
- **Fill with `stall=1`:** 4 dual pushes fill DEPTH=8, `count=8`, `in_ready=0`. A 5th dual push gives `drop_cnt=2` and `count` stays 8. Then, with `count=7`, a dual push accepts slot 0 only and `drop_cnt` becomes 3.
- **Full, concurrent pop and 1 push** (`stall=0`): the push is dropped, `count` 8→7, and `drop_cnt` increments by 1.
- **Wraparound:** 20 single pushes interleaved with pops over a continuously busy queue. The output sequence equals the input sequence exactly, and pointers wrap cleanly.
- **Reset mid-operation** with `count=5` and `drop_cnt=4`: immediately `wen=0`, `count=0`, `drop_cnt=0`, and the old entries never appear.

Source files
------------

// File: rtl/bpb_commit_queue_if.sv
// Bundle between the execute/commit slots, the commit queue and the BPB write port.
// Valid/ready note: in_valid pushes regardless of in_ready (advisory); wen is held while stall is high.
interface bpb_commit_queue_if #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
);
    logic              stall;
    logic [1:0]        in_valid;
    logic [1:0][31:0]  in_pc;
    logic [1:0]        in_taken;
    logic [1:0][31:0]  in_destpc;
    logic              in_ready;
    logic              wen;
    logic [31:0]       pc_commit;
    logic              taken_commit;
    logic [31:0]       destpc_commit;
    logic [PTR_W:0]    count;
    logic [15:0]       drop_cnt;

    modport master (
        output stall, in_valid, in_pc, in_taken, in_destpc,
        input  in_ready, wen, pc_commit, taken_commit, destpc_commit, count, drop_cnt
    );

    modport slave (
        input  stall, in_valid, in_pc, in_taken, in_destpc,
        output in_ready, wen, pc_commit, taken_commit, destpc_commit, count, drop_cnt
    );
endinterface

// File: rtl/bpb_commit_queue.sv
// Dual-push, single-pop FIFO of resolved-branch updates feeding the BPB write port.
// Overflowing updates are dropped (younger first) and counted with saturation.
module bpb_commit_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    bpb_commit_queue_if.slave    bus
);
    logic [31:0]      r_pc     [DEPTH];
    logic             r_taken  [DEPTH];
    logic [31:0]      r_destpc [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic [15:0]      r_drop_cnt;

    logic             w_head_valid;
    logic             w_pop;
    logic [PTR_W:0]   w_free;
    logic [1:0]       w_n_req;
    logic [1:0]       w_n_acc;
    logic [1:0]       w_n_drop;
    logic             w_first_slot;
    logic [PTR_W-1:0] w_wr_ptr_p1;
    logic [16:0]      w_drop_sum;
    logic [PTR_W:0]   w_count_next;

    // Free space is measured before the pop, so a pop never makes room for a same-cycle push.
    always_comb begin
        w_head_valid = (r_count != '0);
        w_pop        = w_head_valid && !bus.stall;
        w_free       = (PTR_W+1)'(DEPTH) - r_count;
        w_n_req      = {1'b0, bus.in_valid[0]} + {1'b0, bus.in_valid[1]};
        if ({{(PTR_W-1){1'b0}}, w_n_req} <= w_free) begin
            w_n_acc = w_n_req;
        end else begin
            w_n_acc = w_free[1:0];
        end
        w_n_drop     = w_n_req - w_n_acc;
        w_first_slot = !bus.in_valid[0];
        w_wr_ptr_p1  = r_wr_ptr + PTR_W'(1);
        w_drop_sum   = {1'b0, r_drop_cnt} + {15'b0, w_n_drop};
        w_count_next = r_count + {{(PTR_W-1){1'b0}}, w_n_acc} - {{PTR_W{1'b0}}, w_pop};
    end

    // Data array carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_n_acc != 2'd0) begin
            r_pc[r_wr_ptr]     <= bus.in_pc[w_first_slot];
            r_taken[r_wr_ptr]  <= bus.in_taken[w_first_slot];
            r_destpc[r_wr_ptr] <= bus.in_destpc[w_first_slot];
        end
        if (w_n_acc == 2'd2) begin
            r_pc[w_wr_ptr_p1]     <= bus.in_pc[1];
            r_taken[w_wr_ptr_p1]  <= bus.in_taken[1];
            r_destpc[w_wr_ptr_p1] <= bus.in_destpc[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_rd_ptr   <= r_rd_ptr + PTR_W'(w_pop);
            r_wr_ptr   <= r_wr_ptr + PTR_W'(w_n_acc);
            r_count    <= w_count_next;
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign bus.wen           = w_head_valid;
    assign bus.pc_commit     = w_head_valid ? r_pc[r_rd_ptr]     : 32'h0;
    assign bus.taken_commit  = w_head_valid ? r_taken[r_rd_ptr]  : 1'b0;
    assign bus.destpc_commit = w_head_valid ? r_destpc[r_rd_ptr] : 32'h0;
    assign bus.in_ready      = (w_free >= (PTR_W+1)'(2));
    assign bus.count         = r_count;
    assign bus.drop_cnt      = r_drop_cnt;
endmodule
